// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC generation, in-order imem requests and a small in-order
// instruction queue toward decode. Optional macro IFETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        misalign_err
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]                 fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]            head_q, head_d;
    logic [PTR_W-1:0]            tail_q, tail_d;
    logic [PTR_W-1:0]            fill_q, fill_d;
    logic [CNT_W-1:0]            used_q, used_d;
    logic [CNT_W-1:0]            inflight_q, inflight_d;
    logic [CNT_W-1:0]            drop_q, drop_d;
    logic [BUF_DEPTH-1:0][31:0]  slot_pc_q, slot_pc_d;
    logic [BUF_DEPTH-1:0][31:0]  slot_instr_q, slot_instr_d;
    logic [BUF_DEPTH-1:0]        slot_filled_q, slot_filled_d;

    logic        halted;
    logic        credit_ok;
    logic        accept;
    logic        pop;
    logic [31:0] redirect_target;

    // Reserved slots plus responses still to be dropped equals inflight plus filled slots.
    assign credit_ok       = ({1'b0, used_q} + {1'b0, drop_q}) < (CNT_W + 1)'(BUF_DEPTH);
    assign imem_req_valid  = !reset && credit_ok && !halted;
    assign imem_req_addr   = fetch_pc_q;
    assign accept          = imem_req_valid && imem_req_ready;

    assign instr_valid     = slot_filled_q[head_q];
    assign instr           = slot_instr_q[head_q];
    assign instr_pc        = slot_pc_q[head_q];
    assign pop             = instr_valid && instr_ready && !redirect_valid;

    assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;

    always_comb begin
        misalign_d = misalign_q;
        if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign halted       = misalign_q;
    assign misalign_err = misalign_q;
`else
    assign halted       = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        fill_d        = fill_q;
        used_d        = used_q;
        inflight_d    = inflight_q + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
        drop_d        = drop_q;
        slot_pc_d     = slot_pc_q;
        slot_instr_d  = slot_instr_q;
        slot_filled_d = slot_filled_q;

        if (redirect_valid) begin
            // Everything still outstanding after this edge belongs to the old stream.
            fetch_pc_d    = redirect_target;
            head_d        = '0;
            tail_d        = '0;
            fill_d        = '0;
            used_d        = '0;
            slot_filled_d = '0;
            drop_d        = inflight_d;
        end else begin
            if (accept) begin
                slot_pc_d[tail_q]     = fetch_pc_q;
                slot_filled_d[tail_q] = 1'b0;
                tail_d                = tail_q + PTR_W'(1);
                fetch_pc_d            = fetch_pc_q + 32'd4;
            end

            if (imem_rsp_valid) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    slot_instr_d[fill_q]  = imem_rsp_data;
                    slot_filled_d[fill_q] = 1'b1;
                    fill_d                = fill_q + PTR_W'(1);
                end
            end

            if (pop) begin
                slot_filled_d[head_q] = 1'b0;
                head_d                = head_q + PTR_W'(1);
            end

            used_d = used_q + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            fill_q        <= '0;
            used_q        <= '0;
            inflight_q    <= '0;
            drop_q        <= '0;
            slot_pc_q     <= '0;
            slot_instr_q  <= '0;
            slot_filled_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            fill_q        <= fill_d;
            used_q        <= used_d;
            inflight_q    <= inflight_d;
            drop_q        <= drop_d;
            slot_pc_q     <= slot_pc_d;
            slot_instr_q  <= slot_instr_d;
            slot_filled_q <= slot_filled_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: in-order memory model with configurable latency and a
// PC/instruction scoreboard. Honours IFETCH_MISALIGN_TRAP_EN when it is defined.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        misalign_err;

    instr_fetch #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .misalign_err   (misalign_err)
    );

    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cycle       = 0;
    int          pops        = 0;
    int          accepts     = 0;
    int          lat_lo      = 1;
    int          lat_hi      = 1;
    int          pops0;
    int          acc0;
    logic [31:0] exp_pc;
    logic [31:0] exp_fetch;
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    // Instruction word the memory model returns for a given address.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return {addr[15:0] ^ addr[31:16], addr[15:0]} ^ 32'h1357_2468;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    // One clock cycle: memory answers, inputs are driven, the scoreboard observes, then the edge.
    task automatic applyStimulus(input logic red_v, input logic [31:0] red_pc,
                                 input logic mem_rdy, input logic dec_rdy);
        redirect_valid = red_v;
        redirect_pc    = red_pc;
        imem_req_ready = mem_rdy;
        instr_ready    = dec_rdy;
        if (reset) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else if (pend_addr.size() > 0 && pend_due[0] <= cycle) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memWord(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        #1;
        if (!reset) begin
            if (instr_valid && dec_rdy && !red_v) begin
                checkOutput("instr_pc", instr_pc, exp_pc);
                checkOutput("instr", instr, memWord(exp_pc));
                exp_pc = exp_pc + 32'd4;
                pops++;
            end
            if (imem_req_valid && mem_rdy) begin
                checkOutput("req_addr", imem_req_addr, exp_fetch);
                exp_fetch = exp_fetch + 32'd4;
                pend_addr.push_back(imem_req_addr);
                pend_due.push_back(cycle + int'($urandom_range(lat_hi, lat_lo)));
                accepts++;
            end
            if (red_v) begin
                exp_pc    = red_pc & 32'hFFFF_FFFC;
                exp_fetch = red_pc & 32'hFFFF_FFFC;
            end
        end
        @(posedge clk);
        @(negedge clk);
        cycle++;
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b0;
        exp_pc         = RESET_PC;
        exp_fetch      = RESET_PC;

        @(negedge clk);
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_instr", instr, 32'd0);
        checkOutput("rst_instr_pc", instr_pc, 32'd0);
        checkOutput("rst_misalign", 32'(misalign_err), 32'd0);

        // First request and first-instruction latency with a 1-cycle memory.
        reset = 1'b0;
        #1;
        checkOutput("first_req_valid", 32'(imem_req_valid), 32'd1);
        checkOutput("first_req_addr", imem_req_addr, RESET_PC);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("lat_not_yet", 32'(instr_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("lat_valid", 32'(instr_valid), 32'd1);
        checkOutput("lat_pc", instr_pc, RESET_PC);

        pops0 = pops;
        repeat (20) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("stream_progress", 32'(pops - pops0 >= 8), 32'd1);

        // Decode stalled: the queue fills and requests stop.
        acc0 = accepts;
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("stall_reqs", 32'(accepts - acc0 <= 2), 32'd1);
        checkOutput("stall_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("stall_head_held", 32'(instr_valid), 32'd1);
        pops0 = pops;
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("stall_release", 32'(pops - pops0 >= 4), 32'd1);

        // Drain, then redirect in a cycle that also accepts a request and receives a response.
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("drained", 32'(instr_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        checkOutput("redir_addr", imem_req_addr, 32'h0000_0100);
        pops0 = pops;
        repeat (12) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("redir_progress", 32'(pops - pops0 >= 2), 32'd1);

        // Reset in the middle of a slow stream with responses outstanding.
        lat_lo = 3;
        lat_hi = 3;
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("mid_rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("mid_rst_instr", instr, 32'd0);
        checkOutput("mid_rst_instr_pc", instr_pc, 32'd0);
        checkOutput("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        reset     = 1'b0;
        exp_pc    = RESET_PC;
        exp_fetch = RESET_PC;
        lat_lo    = 1;
        lat_hi    = 1;
        #1;
        checkOutput("mid_rst_first_addr", imem_req_addr, RESET_PC);
        checkOutput("mid_rst_first_valid", 32'(imem_req_valid), 32'd1);
        pops0 = pops;
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("mid_rst_progress", 32'(pops - pops0 >= 4), 32'd1);

        // Random memory backpressure and 1-3 cycle latency, with one redirect mid-way.
        lat_lo = 1;
        lat_hi = 3;
        pops0  = pops;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(1'(i == 100), 32'h0000_2000, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0));
        end
        checkOutput("random_progress", 32'(pops - pops0 >= 20), 32'd1);

        // Misaligned redirect target.
        lat_lo = 1;
        lat_hi = 1;
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'h0000_0102, 1'b1, 1'b1);
`ifdef IFETCH_MISALIGN_TRAP_EN
        checkOutput("misalign_set", 32'(misalign_err), 32'd1);
        acc0 = accepts;
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("misalign_no_reqs", 32'(accepts - acc0), 32'd0);
        checkOutput("misalign_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("misalign_sticky", 32'(misalign_err), 32'd1);
`else
        checkOutput("misalign_tied", 32'(misalign_err), 32'd0);
        checkOutput("misalign_addr", imem_req_addr, 32'h0000_0100);
        pops0 = pops;
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("misalign_resume", 32'(pops - pops0 >= 2), 32'd1);
`endif
        reset = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("final_rst_misalign", 32'(misalign_err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
